// File: rtl/nibble_unpacker_pkg.sv
// Shared definitions for the nibble unpacker: FSM encoding, nibble width and
// the bit-counter width helper.
package nibble_unpacker_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // Counter must index every bit of a frame: 0 .. NIBBLE_W*nibbles-1.
  function automatic int cnt_width(input int nibbles);
    return $clog2(NIBBLE_W * nibbles);
  endfunction

endpackage

// File: rtl/nibble_place.sv
// Places one nibble's bits (held in arrival order, bit 0 first) into word order:
// MSB-first streams are reversed, LSB-first streams pass straight through.
module nibble_place
  import nibble_unpacker_pkg::*;
(
  input  logic [NIBBLE_W-1:0] nib_i,
  input  logic                rev_i,
  output logic [NIBBLE_W-1:0] placed_o
);

  always_comb begin
    placed_o = nib_i;
    if (!rev_i) begin
      for (int j = 0; j < NIBBLE_W; j++) begin
        placed_o[NIBBLE_W-1-j] = nib_i[j];
      end
    end
  end

endmodule

// File: rtl/nibble_unpacker.sv
// Serial-to-parallel frame assembler: collects NIBBLES*4 bits after a sof,
// reorders each nibble by its latched rev bit and offers the word on a valid/ready handshake.
module nibble_unpacker
  import nibble_unpacker_pkg::*;
#(
  parameter int NIBBLES = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        sdi,
  input  logic                        sdi_valid,
  input  logic                        sof,
  input  logic [NIBBLES-1:0]          rev,
  output logic [NIBBLE_W*NIBBLES-1:0] word,
  output logic                        word_valid,
  input  logic                        word_ready,
  output logic                        overrun,
  output logic                        frame_err
);

  localparam int FRAME_W = NIBBLE_W * NIBBLES;
  localparam int CNT_W   = cnt_width(NIBBLES);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_W - 1);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [FRAME_W-1:0]   shift_q, shift_d;
  logic [NIBBLES-1:0]   rev_q, rev_d;
  logic [FRAME_W-1:0]   word_q, word_d;
  logic                 word_valid_q, word_valid_d;
  logic                 overrun_q, overrun_d;
  logic                 frame_err_q, frame_err_d;
  logic [FRAME_W-1:0]   raw_frame;
  logic [FRAME_W-1:0]   placed;
  logic                 complete;

  // New bits enter at the MSB, so after a full frame raw_frame[i] is arrival bit i.
  assign raw_frame = {sdi, shift_q[FRAME_W-1:1]};

  for (genvar k = 0; k < NIBBLES; k++) begin : g_place
    nibble_place u_place (
      .nib_i    (raw_frame[NIBBLE_W*k +: NIBBLE_W]),
      .rev_i    (rev_q[k]),
      .placed_o (placed[NIBBLE_W*k +: NIBBLE_W])
    );
  end

  always_comb begin
    // NOTE: every signal driven here gets a default first so no path infers a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    rev_d       = rev_q;
    complete    = 1'b0;
    frame_err_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (sdi_valid && sof) begin
          state_d = SHIFT;
          cnt_d   = CNT_W'(1);
          shift_d = {sdi, {(FRAME_W-1){1'b0}}};
          rev_d   = rev;
        end
      end
      SHIFT: begin
        if (sdi_valid) begin
          if (sof) begin
            // Restart on this bit; clearing the shifter keeps stale bits out.
            frame_err_d = 1'b1;
            cnt_d       = CNT_W'(1);
            shift_d     = {sdi, {(FRAME_W-1){1'b0}}};
            rev_d       = rev;
          end else if (cnt_q == LAST_CNT) begin
            complete = 1'b1;
            state_d  = IDLE;
            cnt_d    = '0;
            shift_d  = '0;
          end else begin
            cnt_d   = cnt_q + 1'b1;
            shift_d = raw_frame;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    word_d       = word_q;
    word_valid_d = word_valid_q;
    overrun_d    = 1'b0;
    if (complete) begin
      if (!word_valid_q || word_ready) begin
        word_d       = placed;
        word_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (word_valid_q && word_ready) begin
      word_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state uses non-blocking assignments so all registers update from pre-edge values.
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      shift_q      <= '0;
      rev_q        <= '0;
      word_q       <= '0;
      word_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shift_q      <= shift_d;
      rev_q        <= rev_d;
      word_q       <= word_d;
      word_valid_q <= word_valid_d;
      overrun_q    <= overrun_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign word       = word_q;
  assign word_valid = word_valid_q;
  assign overrun    = overrun_q;
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_nibble_unpacker.sv
// Directed bench for nibble_unpacker (NIBBLES=3) with hand-computed frames.
module tb_nibble_unpacker;

  logic        clk;
  logic        rst;
  logic        sdi;
  logic        sdi_valid;
  logic        sof;
  logic [2:0]  rev;
  logic [11:0] word;
  logic        word_valid;
  logic        word_ready;
  logic        overrun;
  logic        frame_err;

  int checks   = 0;
  int failures = 0;
  int fe_pulses = 0;
  int ov_pulses = 0;
  int fe_mark;
  int ov_mark;

  // Arrival order 1100 0101 1010: bit i of the stream is STREAM[i].
  localparam logic [11:0] STREAM = 12'b0101_1010_0011;
  localparam logic [11:0] ONES   = 12'hFFF;

  nibble_unpacker #(.NIBBLES(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .sdi        (sdi),
    .sdi_valid  (sdi_valid),
    .sof        (sof),
    .rev        (rev),
    .word       (word),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .overrun    (overrun),
    .frame_err  (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_err) fe_pulses++;
    if (overrun)   ov_pulses++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // One valid bit; with gap, an idle cycle carrying junk on every other input comes first.
  task automatic send_bit(input logic b, input logic s, input logic [2:0] r, input bit gap);
    if (gap) begin
      sdi_valid = 1'b0;
      sdi       = ~b;
      sof       = 1'b1;
      rev       = ~r;
      @(posedge clk); #1;
    end
    sdi       = b;
    sof       = s;
    sdi_valid = 1'b1;
    rev       = s ? r : ~r;
    @(posedge clk); #1;
    sdi_valid = 1'b0;
    sof       = 1'b0;
  endtask

  task automatic send_frame(input logic [11:0] bits, input logic [2:0] r, input int n, input bit gap);
    for (int i = 0; i < n; i++) begin
      send_bit(bits[i], i == 0, r, gap);
    end
  endtask

  task automatic idle(input int n);
    sdi_valid = 1'b0;
    sof       = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; sdi = 1'b0; sdi_valid = 1'b0; sof = 1'b0; rev = 3'b000; word_ready = 1'b1;
    #1;
    check("reset_word",      32'(word),       32'h0);
    check("reset_valid",     32'(word_valid), 32'h0);
    check("reset_overrun",   32'(overrun),    32'h0);
    check("reset_frame_err", 32'(frame_err),  32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    idle(1);

    // Basic frame, MSB-first everywhere, with latency check.
    fe_mark = fe_pulses;
    send_frame(STREAM, 3'b000, 11, 1'b0);
    check("lat_before_last", 32'(word_valid), 32'h0);
    send_bit(STREAM[11], 1'b0, 3'b000, 1'b0);
    check("lat_after_last",  32'(word_valid), 32'h1);
    check("word_rev000",     32'(word),       32'hA5C);
    check("no_overrun_free", 32'(overrun),    32'h0);
    idle(1);
    check("handshake_clear", 32'(word_valid), 32'h0);
    check("no_fe_normal",    32'(fe_pulses - fe_mark), 32'h0);

    // Per-nibble bit-order select.
    send_frame(STREAM, 3'b001, 12, 1'b0);
    check("word_rev001", 32'(word), 32'hA53);
    idle(1);
    send_frame(STREAM, 3'b111, 12, 1'b0);
    check("word_rev111", 32'(word), 32'h5A3);
    idle(1);

    // Back-to-back frames with the consumer stalled.
    word_ready = 1'b0;
    ov_mark = ov_pulses;
    send_frame(STREAM, 3'b000, 12, 1'b0);
    check("stall_first_valid", 32'(word_valid), 32'h1);
    check("stall_first_word",  32'(word),       32'hA5C);
    check("stall_first_ovr",   32'(overrun),    32'h0);
    send_frame(STREAM, 3'b111, 12, 1'b0);
    check("overrun_pulse",     32'(overrun),    32'h1);
    check("overrun_word_held", 32'(word),       32'hA5C);
    check("overrun_valid",     32'(word_valid), 32'h1);
    idle(1);
    check("overrun_one_cycle", 32'(overrun),    32'h0);
    check("overrun_count",     32'(ov_pulses - ov_mark), 32'h1);
    check("stall_hold_word",   32'(word),       32'hA5C);
    word_ready = 1'b1;
    idle(1);
    check("stall_release",     32'(word_valid), 32'h0);

    // sof in the middle of a frame restarts it.
    fe_mark = fe_pulses;
    send_frame(ONES, 3'b111, 7, 1'b0);
    send_frame(STREAM, 3'b000, 12, 1'b0);
    check("frame_err_count", 32'(fe_pulses - fe_mark), 32'h1);
    check("restart_word",    32'(word),       32'hA5C);
    check("restart_valid",   32'(word_valid), 32'h1);
    idle(1);

    // Gappy input: every valid bit preceded by an idle cycle.
    send_frame(STREAM, 3'b001, 11, 1'b1);
    check("gap_before_last", 32'(word_valid), 32'h0);
    send_bit(STREAM[11], 1'b0, 3'b001, 1'b1);
    check("gap_valid",       32'(word_valid), 32'h1);
    check("gap_word",        32'(word),       32'hA53);
    idle(1);

    // Asynchronous reset mid-frame with a held word present.
    word_ready = 1'b0;
    send_frame(STREAM, 3'b000, 12, 1'b0);
    check("pre_reset_word",  32'(word),       32'hA5C);
    send_frame(STREAM, 3'b000, 5, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("async_rst_word",  32'(word),       32'h0);
    check("async_rst_valid", 32'(word_valid), 32'h0);
    check("async_rst_ovr",   32'(overrun),    32'h0);
    check("async_rst_fe",    32'(frame_err),  32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    word_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      send_bit(ONES[i], 1'b0, 3'b000, 1'b0);
    end
    check("no_sof_ignored",  32'(word_valid), 32'h0);
    send_frame(STREAM, 3'b111, 12, 1'b0);
    check("post_reset_word", 32'(word),       32'h5A3);
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
